sdram_arbit: RTL and testbench

- Central SDRAM command arbiter; consumer of the refresh, write and read command generators, and the only driver of the SDRAM command/address/data pins.
- Passes init-sequence commands through until init completes.
- Then grants the bus to one requester at a time: refresh > write/read, with write and read alternating round-robin.
- Drives the granted requester's command, bank, address and data onto the pins with zero added latency.

---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_arbit_mux.sv | 62 ++++++
 rtl/sdram_arbit.sv | 127 ++++++++++++
 tb/tb_sdram_arbit.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encodings and default bus widths.
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int BA_W_DEF   = 2;
    localparam int DQ_W_DEF   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } sdram_cmd_t;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT    = 3'd0;
    localparam state_t ST_ARBIT   = 3'd1;
    localparam state_t ST_REFRESH = 3'd2;
    localparam state_t ST_WRITE   = 3'd3;
    localparam state_t ST_READ    = 3'd4;

endpackage

// File: rtl/sdram_arbit_mux.sv
// Pin mux: routes the owning requester's command/bank/address/data to the SDRAM pins.
// Latency: purely combinational from the state register, zero cycles.
// Backpressure: none; ownership is decided entirely by the arbiter state.
module sdram_arbit_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  state_t            state,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        refresh_cmd,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output sdram_cmd_t        cmd,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr,
    output logic [DQ_W-1:0]   dq_out,
    output logic              dq_oe
);

    always_comb begin
        cmd    = CMD_NOP;
        ba     = '0;
        addr   = '1;
        dq_out = '0;
        dq_oe  = 1'b0;
        case (state)
            ST_INIT: begin
                cmd  = init_cmd;
                ba   = init_ba;
                addr = init_addr;
            end
            ST_REFRESH: begin
                cmd = refresh_cmd;
            end
            ST_WRITE: begin
                cmd    = wr_cmd;
                ba     = wr_ba;
                addr   = wr_addr;
                dq_out = wr_dq;
                dq_oe  = wr_dq_oe;
            end
            ST_READ: begin
                cmd  = rd_cmd;
                ba   = rd_ba;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init pass-through, then refresh > write/read (round-robin) ownership.
// Latency: grant ack one cycle after request is seen in ARBIT; pins follow owner with zero delay.
// Backpressure: owner holds the bus until its *_end; waiting refresh is flagged via refresh_pending.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  logic              sysclk_100M,
    input  logic              rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              arbit_refresh_req,
    output logic              arbit_refresh_ack,
    input  logic [3:0]        refresh_cmd,
    input  logic              refresh_end,
    input  logic              wr_req,
    output logic              wr_ack,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    input  logic              rd_req,
    output logic              rd_ack,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              refresh_pending,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    state_t     state;
    state_t     next_state;
    state_t     last_grant;
    sdram_cmd_t mux_cmd;
    logic       grant_evt;

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:    if (init_end) next_state = ST_ARBIT;
            ST_ARBIT: begin
                if (arbit_refresh_req)
                    next_state = ST_REFRESH;
                else if (wr_req && rd_req)
                    next_state = (last_grant == ST_WRITE) ? ST_READ : ST_WRITE;
                else if (wr_req)
                    next_state = ST_WRITE;
                else if (rd_req)
                    next_state = ST_READ;
            end
            // Every exit lands in ARBIT so the bus always gets at least one NOP between owners.
            ST_REFRESH: if (refresh_end) next_state = ST_ARBIT;
            ST_WRITE:   if (wr_end)      next_state = ST_ARBIT;
            ST_READ:    if (rd_end)      next_state = ST_ARBIT;
            default:    next_state = ST_INIT;
        endcase
    end

    assign grant_evt = (state == ST_ARBIT);

    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_INIT;
            last_grant        <= ST_READ;
            arbit_refresh_ack <= 1'b0;
            wr_ack            <= 1'b0;
            rd_ack            <= 1'b0;
        end else begin
            state             <= next_state;
            arbit_refresh_ack <= grant_evt && (next_state == ST_REFRESH);
            wr_ack            <= grant_evt && (next_state == ST_WRITE);
            rd_ack            <= grant_evt && (next_state == ST_READ);
            if (grant_evt && (next_state == ST_WRITE || next_state == ST_READ))
                last_grant <= next_state;
        end
    end

    assign refresh_pending = arbit_refresh_req && (state == ST_WRITE || state == ST_READ);
    assign sdram_cke       = 1'b1;

    sdram_arbit_mux #(
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W),
        .DQ_W   (DQ_W)
    ) u_mux (
        .state       (state),
        .init_cmd    (init_cmd),
        .init_ba     (init_ba),
        .init_addr   (init_addr),
        .refresh_cmd (refresh_cmd),
        .wr_cmd      (wr_cmd),
        .wr_ba       (wr_ba),
        .wr_addr     (wr_addr),
        .wr_dq       (wr_dq),
        .wr_dq_oe    (wr_dq_oe),
        .rd_cmd      (rd_cmd),
        .rd_ba       (rd_ba),
        .rd_addr     (rd_addr),
        .cmd         (mux_cmd),
        .ba          (sdram_ba),
        .addr        (sdram_addr),
        .dq_out      (sdram_dq_out),
        .dq_oe       (sdram_dq_oe)
    );

    assign sdram_cs_n  = mux_cmd.cs_n;
    assign sdram_ras_n = mux_cmd.ras_n;
    assign sdram_cas_n = mux_cmd.cas_n;
    assign sdram_we_n  = mux_cmd.we_n;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: behavioural refresh/write/read requesters plus a grant scoreboard.
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int ADDR_W   = 13;
    localparam int BA_W     = 2;
    localparam int DQ_W     = 16;
    localparam int K_REF    = 1;
    localparam int K_WR     = 2;
    localparam int K_RD     = 3;
    localparam int XFER_LEN = 4;
    localparam logic [DQ_W-1:0] WR_DATA = 16'hA5C3;

    logic              sysclk_100M = 1'b0;
    logic              rst_n = 1'b1;
    logic [3:0]        init_cmd = CMD_NOP;
    logic [BA_W-1:0]   init_ba = '0;
    logic [ADDR_W-1:0] init_addr = '0;
    logic              init_end = 1'b0;
    logic              arbit_refresh_req = 1'b0;
    logic              arbit_refresh_ack;
    logic [3:0]        refresh_cmd = CMD_NOP;
    logic              refresh_end = 1'b1;
    logic              wr_req = 1'b0;
    logic              wr_ack;
    logic              wr_end = 1'b0;
    logic [3:0]        wr_cmd = CMD_WRITE;
    logic [BA_W-1:0]   wr_ba = 2'd2;
    logic [ADDR_W-1:0] wr_addr = 13'h0123;
    logic [DQ_W-1:0]   wr_dq = WR_DATA;
    logic              wr_dq_oe = 1'b1;
    logic              rd_req = 1'b0;
    logic              rd_ack;
    logic              rd_end = 1'b0;
    logic [3:0]        rd_cmd = CMD_READ;
    logic [BA_W-1:0]   rd_ba = 2'd3;
    logic [ADDR_W-1:0] rd_addr = 13'h0456;
    logic              refresh_pending;
    logic              sdram_cke;
    logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;
    logic [3:0]        pin_cmd;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_q[$];
    int obs_kind[$];
    int obs_cyc[$];
    int ref_add = 0, ref_done = 0, ref_cnt = -1;
    int wr_add = 0, wr_done = 0, wr_cnt = -1;
    int rd_add = 0, rd_done = 0, rd_cnt = -1;

    assign pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    always #5 sysclk_100M = ~sysclk_100M;

    sdram_arbit dut (
        .sysclk_100M       (sysclk_100M),
        .rst_n             (rst_n),
        .init_cmd          (init_cmd),
        .init_ba           (init_ba),
        .init_addr         (init_addr),
        .init_end          (init_end),
        .arbit_refresh_req (arbit_refresh_req),
        .arbit_refresh_ack (arbit_refresh_ack),
        .refresh_cmd       (refresh_cmd),
        .refresh_end       (refresh_end),
        .wr_req            (wr_req),
        .wr_ack            (wr_ack),
        .wr_end            (wr_end),
        .wr_cmd            (wr_cmd),
        .wr_ba             (wr_ba),
        .wr_addr           (wr_addr),
        .wr_dq             (wr_dq),
        .wr_dq_oe          (wr_dq_oe),
        .rd_req            (rd_req),
        .rd_ack            (rd_ack),
        .rd_end            (rd_end),
        .rd_cmd            (rd_cmd),
        .rd_ba             (rd_ba),
        .rd_addr           (rd_addr),
        .refresh_pending   (refresh_pending),
        .sdram_cke         (sdram_cke),
        .sdram_cs_n        (sdram_cs_n),
        .sdram_ras_n       (sdram_ras_n),
        .sdram_cas_n       (sdram_cas_n),
        .sdram_we_n        (sdram_we_n),
        .sdram_ba          (sdram_ba),
        .sdram_addr        (sdram_addr),
        .sdram_dq_out      (sdram_dq_out),
        .sdram_dq_oe       (sdram_dq_oe)
    );

    always @(posedge sysclk_100M) cyc++;

    // Refresh generator: REFRESH one cycle after ack, end seven cycles after ack, end high when idle.
    always @(negedge sysclk_100M) begin
        if (!rst_n) begin
            ref_cnt = -1;
            refresh_cmd = CMD_NOP;
            refresh_end = 1'b1;
        end else if (ref_cnt >= 0) begin
            ref_cnt++;
            refresh_cmd = (ref_cnt == 1) ? CMD_REFRESH : CMD_NOP;
            refresh_end = (ref_cnt == 7);
            if (ref_cnt == 7) ref_cnt = -1;
        end else if (arbit_refresh_ack) begin
            ref_done++;
            ref_cnt = 0;
            refresh_end = 1'b0;
        end else begin
            refresh_cmd = CMD_NOP;
            refresh_end = !(ref_add > ref_done);
        end
        arbit_refresh_req = (ref_add > ref_done);
    end

    always @(negedge sysclk_100M) begin
        if (!rst_n) begin
            wr_cnt = -1;
            wr_end = 1'b0;
        end else if (wr_cnt >= 0) begin
            wr_cnt++;
            wr_end = (wr_cnt == XFER_LEN - 1);
            if (wr_end) wr_cnt = -1;
        end else begin
            wr_end = 1'b0;
            if (wr_ack) begin
                wr_done++;
                wr_cnt = 0;
            end
        end
        wr_req = (wr_add > wr_done);
    end

    always @(negedge sysclk_100M) begin
        if (!rst_n) begin
            rd_cnt = -1;
            rd_end = 1'b0;
        end else if (rd_cnt >= 0) begin
            rd_cnt++;
            rd_end = (rd_cnt == XFER_LEN - 1);
            if (rd_end) rd_cnt = -1;
        end else begin
            rd_end = 1'b0;
            if (rd_ack) begin
                rd_done++;
                rd_cnt = 0;
            end
        end
        rd_req = (rd_add > rd_done);
    end

    // Grant monitor: logs every ack pulse with the cycle it appeared in.
    always @(negedge sysclk_100M) begin
        #1;
        if (arbit_refresh_ack) begin obs_kind.push_back(K_REF); obs_cyc.push_back(cyc); end
        if (wr_ack)            begin obs_kind.push_back(K_WR);  obs_cyc.push_back(cyc); end
        if (rd_ack)            begin obs_kind.push_back(K_RD);  obs_cyc.push_back(cyc); end
    end

    task automatic step();
        @(negedge sysclk_100M);
        #2;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        init_end = 1'b0;
        init_cmd = CMD_PRECHARGE;
        init_ba = 2'd1;
        init_addr = 13'h0400;
        #3;
        vectors++;
        if (pin_cmd !== CMD_PRECHARGE || sdram_ba !== 2'd1 || sdram_addr !== 13'h0400) begin
            miscompares++;
            $display("FAIL reset_pins: cmd=%b ba=%0d addr=%h, expected 0010/1/0400", pin_cmd, sdram_ba, sdram_addr);
        end
        vectors++;
        if ({arbit_refresh_ack, wr_ack, rd_ack, sdram_dq_oe, refresh_pending, sdram_cke} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_ctrl: acks/oe/pend/cke=%b, expected 000001",
                     {arbit_refresh_ack, wr_ack, rd_ack, sdram_dq_oe, refresh_pending, sdram_cke});
        end
        step();
        rst_n = 1'b1;
        rd_add++;
        exp_q.push_back(K_RD);
        repeat (3) step();
        vectors++;
        if (obs_kind.size() != 0 || pin_cmd !== CMD_PRECHARGE) begin
            miscompares++;
            $display("FAIL init_hold: grants=%0d cmd=%b, expected 0 grants, cmd 0010", obs_kind.size(), pin_cmd);
        end
    endtask

    task automatic test_init_exit();
        int got, exp;
        init_end = 1'b1;
        #1;
        vectors++;
        if (pin_cmd !== CMD_PRECHARGE) begin
            miscompares++;
            $display("FAIL init_edge: cmd=%b, expected 0010 until next edge", pin_cmd);
        end
        step();
        vectors++;
        if (pin_cmd !== CMD_NOP || sdram_ba !== 2'd0 || sdram_addr !== 13'h1FFF) begin
            miscompares++;
            $display("FAIL arbit_pins: cmd=%b ba=%0d addr=%h, expected 0111/0/1fff", pin_cmd, sdram_ba, sdram_addr);
        end
        step();
        vectors++;
        if (rd_ack !== 1'b1 || pin_cmd !== CMD_READ || sdram_ba !== 2'd3 || sdram_addr !== 13'h0456 || sdram_dq_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL read_grant: ack=%b cmd=%b ba=%0d addr=%h oe=%b, expected 1/0101/3/0456/0",
                     rd_ack, pin_cmd, sdram_ba, sdram_addr, sdram_dq_oe);
        end
        got = 0; exp = -1;
        if (obs_kind.size() > 0) begin got = obs_kind.pop_front(); void'(obs_cyc.pop_front()); end
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL init_grant_kind: got %0d, expected %0d", got, exp);
        end
        repeat (5) step();
    endtask

    task automatic test_round_robin();
        int got, exp, gc, prev;
        wr_add += 2;
        rd_add += 2;
        exp_q.push_back(K_WR); exp_q.push_back(K_RD);
        exp_q.push_back(K_WR); exp_q.push_back(K_RD);
        for (int i = 0; i < 40 && obs_kind.size() < 4; i++) step();
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            got = 0; gc = -1; exp = -1;
            if (obs_kind.size() > 0) begin got = obs_kind.pop_front(); gc = obs_cyc.pop_front(); end
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rr_kind%0d: got %0d, expected %0d", i, got, exp);
            end
            if (i > 0) begin
                vectors++;
                if (gc - prev !== XFER_LEN + 1) begin
                    miscompares++;
                    $display("FAIL rr_gap%0d: %0d cycles between grants, expected %0d", i, gc - prev, XFER_LEN + 1);
                end
            end
            prev = gc;
        end
        repeat (6) step();
    endtask

    task automatic test_refresh();
        int t_req, t_ack, t_cmd, n_ref, n_ack, got, exp;
        t_req = -1; t_ack = -1; t_cmd = -1; n_ref = 0; n_ack = 0;
        ref_add++;
        exp_q.push_back(K_REF);
        for (int c = 0; c < 16; c++) begin
            step();
            if (arbit_refresh_req && t_req < 0) t_req = c;
            if (arbit_refresh_ack) begin n_ack++; t_ack = c; end
            if (pin_cmd === CMD_REFRESH) begin n_ref++; t_cmd = c; end
        end
        vectors++;
        if (t_ack !== t_req + 1 || n_ack !== 1) begin
            miscompares++;
            $display("FAIL ref_ack: req@%0d ack@%0d width %0d, expected ack@req+1 width 1", t_req, t_ack, n_ack);
        end
        vectors++;
        if (n_ref !== 1 || t_cmd !== t_ack + 1) begin
            miscompares++;
            $display("FAIL ref_cmd: %0d REFRESH cmds, last@%0d, expected 1 at ack+1 (%0d)", n_ref, t_cmd, t_ack + 1);
        end
        got = 0; exp = -1;
        if (obs_kind.size() > 0) begin got = obs_kind.pop_front(); void'(obs_cyc.pop_front()); end
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ref_kind: got %0d, expected %0d", got, exp);
        end
    endtask

    task automatic test_priority();
        int got, exp, gc, prev;
        ref_add++;
        wr_add++;
        exp_q.push_back(K_REF);
        exp_q.push_back(K_WR);
        for (int i = 0; i < 40 && obs_kind.size() < 2; i++) step();
        prev = -1;
        for (int i = 0; i < 2; i++) begin
            got = 0; gc = -1; exp = -1;
            if (obs_kind.size() > 0) begin got = obs_kind.pop_front(); gc = obs_cyc.pop_front(); end
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL prio_kind%0d: got %0d, expected %0d", i, got, exp);
            end
            if (i == 1) begin
                vectors++;
                if (gc - prev !== 9) begin
                    miscompares++;
                    $display("FAIL prio_gap: write ack %0d cycles after refresh ack, expected 9", gc - prev);
                end
            end
            prev = gc;
        end
        repeat (6) step();
    endtask

    task automatic test_pending();
        int got, exp;
        bit seen;
        wr_add++;
        exp_q.push_back(K_WR);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = wr_ack;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL pend_wr_ack: no write ack within 10 cycles, expected one");
        end
        ref_add++;
        exp_q.push_back(K_REF);
        step();
        vectors++;
        if (refresh_pending !== 1'b1 || pin_cmd !== CMD_WRITE || sdram_dq_oe !== 1'b1 || sdram_dq_out !== WR_DATA) begin
            miscompares++;
            $display("FAIL pend_write: pend=%b cmd=%b oe=%b dq=%h, expected 1/0100/1/%h",
                     refresh_pending, pin_cmd, sdram_dq_oe, sdram_dq_out, WR_DATA);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (refresh_pending !== 1'b1) begin
                miscompares++;
                $display("FAIL pend_hold%0d: refresh_pending=%b, expected 1", i, refresh_pending);
            end
        end
        step();
        vectors++;
        if (refresh_pending !== 1'b0 || sdram_dq_oe !== 1'b0 || sdram_dq_out !== '0 || pin_cmd !== CMD_NOP || arbit_refresh_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_arbit: pend=%b oe=%b dq=%h cmd=%b rack=%b, expected 0/0/0000/0111/0",
                     refresh_pending, sdram_dq_oe, sdram_dq_out, pin_cmd, arbit_refresh_ack);
        end
        step();
        vectors++;
        if (arbit_refresh_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_ref_ack: arbit_refresh_ack=%b, expected 1", arbit_refresh_ack);
        end
        for (int i = 0; i < 2; i++) begin
            got = 0; exp = -1;
            if (obs_kind.size() > 0) begin got = obs_kind.pop_front(); void'(obs_cyc.pop_front()); end
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL pend_kind%0d: got %0d, expected %0d", i, got, exp);
            end
        end
        repeat (10) step();
    endtask

    task automatic test_reset_mid();
        int got, exp;
        bit seen;
        ref_add++;
        exp_q.push_back(K_REF);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = arbit_refresh_ack;
        end
        got = 0; exp = -1;
        if (obs_kind.size() > 0) begin got = obs_kind.pop_front(); void'(obs_cyc.pop_front()); end
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++;
        if (!seen || got !== exp) begin
            miscompares++;
            $display("FAIL rst_mid_ack: seen=%b kind=%0d, expected ack of kind %0d", seen, got, exp);
        end
        init_cmd = CMD_MRS;
        init_ba = 2'd0;
        init_addr = 13'h0033;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({arbit_refresh_ack, wr_ack, rd_ack} !== 3'b000 || pin_cmd !== CMD_MRS || sdram_addr !== 13'h0033) begin
            miscompares++;
            $display("FAIL rst_mid_pins: acks=%b cmd=%b addr=%h, expected 000/0000/0033",
                     {arbit_refresh_ack, wr_ack, rd_ack}, pin_cmd, sdram_addr);
        end
        step();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (pin_cmd !== CMD_MRS) begin
            miscompares++;
            $display("FAIL rst_mid_release: cmd=%b, expected 0000 before next edge", pin_cmd);
        end
        step();
        vectors++;
        if (pin_cmd !== CMD_NOP || sdram_addr !== 13'h1FFF) begin
            miscompares++;
            $display("FAIL rst_mid_arbit: cmd=%b addr=%h, expected 0111/1fff", pin_cmd, sdram_addr);
        end
        repeat (3) step();
        vectors++;
        if (obs_kind.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: %0d grants after reset, expected 0", obs_kind.size());
        end
    endtask

    initial begin
        test_reset();
        test_init_exit();
        test_round_robin();
        test_refresh();
        test_priority();
        test_pending();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected grants never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
